// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/almost-empty
// thresholds, synchronous flush, read-data valid and sticky overflow/underflow.
// Optional feature macro: SYNC_FIFO_FWFT_EN selects first-word-fall-through
// (combinational head-of-queue dout, valid = !empty); undefined gives a
// registered dout with one-cycle read latency.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr,
  input  logic [DATA_W-1:0]        din,
  input  logic                     rd,
  output logic [DATA_W-1:0]        dout,
  output logic                     valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_ok, rd_ok;

  // Flags decode the registered count so they move together with it.
  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == CW'(DEPTH));
    almost_empty = (count_q <= CW'(AE_LEVEL));
    almost_full  = (count_q >= CW'(AF_LEVEL));
    count        = count_q;
    overflow     = ovf_q;
    underflow    = udf_q;
  end

  // Accept rules: a read frees a slot, so a full FIFO still takes a write
  // alongside a read; a read of an empty FIFO is always refused.
  always_comb begin
    wr_ok = wr && (!full || rd);
    rd_ok = rd && !empty;
  end

  // Next-state for pointers, count and sticky error flags; flush wins.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + AW'(1);
      if (rd_ok) rptr_d = rptr_q + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (wr && !wr_ok) ovf_d = 1'b1;
      if (rd && !rd_ok) udf_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!clr && wr_ok) mem[wptr_q] <= din;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always visible; rd simply acknowledges and pops it.
  always_comb begin
    dout  = mem[rptr_q];
    valid = !empty;
  end
`else
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;

  // Registered read port: dout updates only on an accepted read.
  always_comb begin
    dout_d  = dout_q;
    valid_d = 1'b0;
    if (!clr && rd_ok) begin
      dout_d  = mem[rptr_q];
      valid_d = 1'b1;
    end
  end

  // Read data and valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;
`endif

endmodule
